// File: rtl/updown_counter_mod_if.sv
// rtl/updown_counter_mod_if.sv - control and count signal bundle for updown_counter_mod
interface updown_counter_mod_if #(
  parameter int WIDTH = 8
);
  logic             test;
  logic             en;
  logic             ud;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] cnt;
  logic             tc;
  logic             ovf;

  modport master (
    output test, en, ud, clr, load, load_val, ovf_clr,
    input  cnt, tc, ovf
  );

  modport slave (
    input  test, en, ud, clr, load, load_val, ovf_clr,
    output cnt, tc, ovf
  );
endinterface

// File: rtl/updown_counter_mod.sv
// rtl/updown_counter_mod.sv - up/down counter with modulus, prescaler, load/clear, wrap or saturate
module updown_counter_mod #(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int PRESCALE = 1,
  parameter bit SATURATE = 1'b0
) (
  input logic              clk,
  input logic              rst,
  updown_counter_mod_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV     = WIDTH'(MAX_VAL);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE-1);

  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic             ovf_q;
  logic [PW-1:0]    pre;

  logic [PW-1:0]    pre_nxt;
  logic             tick;
  logic [WIDTH-1:0] eff;
  logic             at_bound;
  logic [WIDTH-1:0] cnt_step;
  logic [WIDTH-1:0] load_clamped;
  logic             bound_ev;

  // An out-of-range count behaves as if it sat at the top of the range.
  assign eff          = (cnt_q > MAXV) ? MAXV : cnt_q;
  assign load_clamped = (bus.load_val > MAXV) ? MAXV : bus.load_val;

  always_comb begin
    tick    = 1'b0;
    pre_nxt = pre;
    if (PRESCALE == 1 || bus.test) begin
      tick    = bus.en;
      pre_nxt = '0;
    end else if (bus.en) begin
      if (pre == PRE_LAST) begin
        tick    = 1'b1;
        pre_nxt = '0;
      end else begin
        pre_nxt = pre + 1'b1;
      end
    end
  end

  assign at_bound = tick && (bus.ud ? (eff == MAXV) : (eff == '0));
  assign bound_ev = at_bound && !bus.clr && !bus.load;

  always_comb begin
    cnt_step = cnt_q;
    if (at_bound) begin
      cnt_step = SATURATE ? eff : (bus.ud ? '0 : MAXV);
    end else if (tick) begin
      cnt_step = bus.ud ? (eff + 1'b1) : (eff - 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
      pre   <= '0;
    end else begin
      if (bus.clr) begin
        cnt_q <= '0;
        pre   <= '0;
        tc_q  <= 1'b0;
      end else if (bus.load) begin
        cnt_q <= load_clamped;
        pre   <= '0;
        tc_q  <= 1'b0;
      end else begin
        cnt_q <= cnt_step;
        pre   <= pre_nxt;
        tc_q  <= at_bound;
      end
      // A boundary event on the same edge outranks the clear request.
      if (bound_ev) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.cnt = cnt_q;
  assign bus.tc  = tc_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb/tb_updown_counter_mod.sv - self-checking bench for updown_counter_mod
module tb_updown_counter_mod;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       test = 1'b0, en = 1'b0, ud = 1'b0, clr = 1'b0, load = 1'b0, ovf_clr = 1'b0;
  logic [3:0] load_val = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  updown_counter_mod_if #(.WIDTH(4)) ifw ();
  updown_counter_mod_if #(.WIDTH(4)) ifp ();
  updown_counter_mod_if #(.WIDTH(4)) ifs ();

  assign ifw.test = test; assign ifw.en = en; assign ifw.ud = ud; assign ifw.clr = clr;
  assign ifw.load = load; assign ifw.load_val = load_val; assign ifw.ovf_clr = ovf_clr;
  assign ifp.test = test; assign ifp.en = en; assign ifp.ud = ud; assign ifp.clr = clr;
  assign ifp.load = load; assign ifp.load_val = load_val; assign ifp.ovf_clr = ovf_clr;
  assign ifs.test = test; assign ifs.en = en; assign ifs.ud = ud; assign ifs.clr = clr;
  assign ifs.load = load; assign ifs.load_val = load_val; assign ifs.ovf_clr = ovf_clr;

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .bus(ifw.slave));
  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .SATURATE(1'b0)) u_pre (
    .clk(clk), .rst(rst), .bus(ifp.slave));
  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .bus(ifs.slave));

  logic [3:0] d_cnt [3];
  logic       d_tc  [3];
  logic       d_ovf [3];
  assign d_cnt[0] = ifw.cnt; assign d_tc[0] = ifw.tc; assign d_ovf[0] = ifw.ovf;
  assign d_cnt[1] = ifp.cnt; assign d_tc[1] = ifp.tc; assign d_ovf[1] = ifp.ovf;
  assign d_cnt[2] = ifs.cnt; assign d_tc[2] = ifs.tc; assign d_ovf[2] = ifs.ovf;

  // Reference model: counter value, enabled cycles since last step, flags.
  int P_PRE [3] = '{1, 3, 3};
  int P_SAT [3] = '{0, 0, 1};
  int m_cnt [3];
  int m_pre [3];
  int m_tc  [3];
  int m_ovf [3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int eff;
      bit tk;
      bit bnd;
      eff = (m_cnt[i] > 9) ? 9 : m_cnt[i];
      tk  = 1'b0;
      bnd = 1'b0;
      if (clr) begin
        m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > 9) ? 9 : int'(load_val);
        m_pre[i] = 0; m_tc[i] = 0;
      end else begin
        if (P_PRE[i] == 1 || test) begin
          tk = en; m_pre[i] = 0;
        end else if (en) begin
          m_pre[i] = m_pre[i] + 1;
          if (m_pre[i] == P_PRE[i]) begin tk = 1'b1; m_pre[i] = 0; end
        end
        bnd = tk && (ud ? (eff == 9) : (eff == 0));
        if (bnd) m_cnt[i] = (P_SAT[i] != 0) ? eff : (ud ? 0 : 9);
        else if (tk) m_cnt[i] = ud ? eff + 1 : eff - 1;
        m_tc[i] = bnd ? 1 : 0;
      end
      if (bnd) m_ovf[i] = 1;
      else if (ovf_clr) m_ovf[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    test = 0; en = 0; ud = 0; clr = 0; load = 0; ovf_clr = 0; load_val = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (d_cnt[i] !== 4'd0 || d_tc[i] !== 1'b0 || d_ovf[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset inst=%0d got cnt=%0d tc=%b ovf=%b required 0/0/0", i, d_cnt[i], d_tc[i], d_ovf[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_wrap_up();
    int exp_cnt;
    en = 1; ud = 1;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_cnt = k % 10;
      n_cmp++;
      if (ifw.cnt !== exp_cnt[3:0] || ifw.tc !== (k == 10) || ifw.ovf !== (k >= 10)) begin
        n_err++;
        $display("FAIL wrap_up k=%0d got cnt=%0d tc=%b ovf=%b required %0d/%b/%b",
                 k, ifw.cnt, ifw.tc, ifw.ovf, exp_cnt, k == 10, k >= 10);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_down();
    int exp_c [3] = '{9, 8, 7};
    int exp_t [3] = '{1, 0, 0};
    clr = 1;
    step();
    clr = 0;
    n_cmp++;
    if (ifw.cnt !== 4'd0 || ifw.ovf !== 1'b1) begin
      n_err++;
      $display("FAIL clr_keeps_ovf got cnt=%0d ovf=%b required 0/1", ifw.cnt, ifw.ovf);
    end
    en = 1; ud = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (ifw.cnt !== exp_c[k][3:0] || ifw.tc !== exp_t[k][0]) begin
        n_err++;
        $display("FAIL wrap_down k=%0d got cnt=%0d tc=%b required %0d/%0d", k, ifw.cnt, ifw.tc, exp_c[k], exp_t[k]);
      end
    end
    en = 0; ovf_clr = 1;
    step();
    ovf_clr = 0;
    n_cmp++;
    if (ifw.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr got ovf=%b required 0", ifw.ovf);
    end
    idle_inputs();
  endtask

  task automatic test_prescale();
    int en_seq [5] = '{1, 0, 0, 1, 1};
    int exp_c  [5] = '{6, 6, 6, 6, 7};
    int exp_k;
    clr = 1;
    step();
    clr = 0; en = 1; ud = 1; test = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp_k = k / 3;
      n_cmp++;
      if (ifp.cnt !== exp_k[3:0]) begin
        n_err++;
        $display("FAIL prescale k=%0d got cnt=%0d required %0d", k, ifp.cnt, exp_k);
      end
    end
    test = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp_k = 3 + k;
      n_cmp++;
      if (ifp.cnt !== exp_k[3:0]) begin
        n_err++;
        $display("FAIL test_bypass k=%0d got cnt=%0d required %0d", k, ifp.cnt, exp_k);
      end
    end
    test = 0;
    for (int k = 0; k < 5; k++) begin
      en = en_seq[k][0];
      step();
      n_cmp++;
      if (ifp.cnt !== exp_c[k][3:0]) begin
        n_err++;
        $display("FAIL en_gap k=%0d got cnt=%0d required %0d", k, ifp.cnt, exp_c[k]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    load_val = 4'd9; load = 1;
    step();
    load = 0;
    n_cmp++;
    if (ifs.cnt !== 4'd9 || ifs.tc !== 1'b0) begin
      n_err++;
      $display("FAIL sat_load got cnt=%0d tc=%b required 9/0", ifs.cnt, ifs.tc);
    end
    en = 1; ud = 1; test = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (ifs.cnt !== 4'd9 || ifs.tc !== 1'b1 || ifs.ovf !== 1'b1) begin
        n_err++;
        $display("FAIL sat_hold k=%0d got cnt=%0d tc=%b ovf=%b required 9/1/1", k, ifs.cnt, ifs.tc, ifs.ovf);
      end
    end
    en = 0; test = 0;
    load_val = 4'd15; load = 1;
    step();
    n_cmp++;
    if (ifs.cnt !== 4'd9 || ifw.cnt !== 4'd9) begin
      n_err++;
      $display("FAIL load_clamp got sat=%0d wrap=%0d required 9/9", ifs.cnt, ifw.cnt);
    end
    load_val = 4'd5; clr = 1;
    step();
    n_cmp++;
    if (ifs.cnt !== 4'd0) begin
      n_err++;
      $display("FAIL clr_over_load got cnt=%0d required 0", ifs.cnt);
    end
    idle_inputs();
  endtask

  task automatic test_priority();
    load_val = 4'd9; load = 1;
    step();
    load_val = 4'd3; en = 1; ud = 1;
    step();
    n_cmp++;
    if (ifw.cnt !== 4'd3 || ifw.tc !== 1'b0) begin
      n_err++;
      $display("FAIL load_over_step got cnt=%0d tc=%b required 3/0", ifw.cnt, ifw.tc);
    end
    load_val = 4'd9;
    step();
    load = 0; ovf_clr = 1;
    step();
    n_cmp++;
    if (ifw.cnt !== 4'd0 || ifw.tc !== 1'b1 || ifw.ovf !== 1'b1) begin
      n_err++;
      $display("FAIL set_over_clear got cnt=%0d tc=%b ovf=%b required 0/1/1", ifw.cnt, ifw.tc, ifw.ovf);
    end
    en = 0;
    step();
    n_cmp++;
    if (ifw.ovf !== 1'b0 || ifw.tc !== 1'b0) begin
      n_err++;
      $display("FAIL clear_after got tc=%b ovf=%b required 0/0", ifw.tc, ifw.ovf);
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    int exp_c [3] = '{0, 0, 1};
    clr = 1;
    step();
    clr = 0; en = 1; ud = 1; test = 1;
    repeat (5) step();
    n_cmp++;
    if (ifp.cnt !== 4'd5) begin
      n_err++;
      $display("FAIL pre_reset_cnt got %0d required 5", ifp.cnt);
    end
    en = 0; test = 0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (ifp.cnt !== 4'd0 || ifp.tc !== 1'b0 || ifp.ovf !== 1'b0 || ifs.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got cnt=%0d tc=%b ovf=%b sat_ovf=%b required 0/0/0/0",
               ifp.cnt, ifp.tc, ifp.ovf, ifs.ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    en = 1; ud = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (ifp.cnt !== exp_c[k][3:0]) begin
        n_err++;
        $display("FAIL post_reset k=%0d got cnt=%0d required %0d", k, ifp.cnt, exp_c[k]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      en       = ($urandom_range(0, 9) < 7);
      ud       = ($urandom_range(0, 9) < 6);
      test     = ($urandom_range(0, 9) < 2);
      clr      = ($urandom_range(0, 39) == 0);
      load     = ($urandom_range(0, 19) == 0);
      ovf_clr  = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom_range(0, 15));
      step();
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (d_cnt[i] !== m_cnt[i][3:0] || d_tc[i] !== m_tc[i][0] || d_ovf[i] !== m_ovf[i][0]) begin
          n_err++;
          $display("FAIL random n=%0d inst=%0d got cnt=%0d tc=%b ovf=%b required %0d/%0d/%0d",
                   n, i, d_cnt[i], d_tc[i], d_ovf[i], m_cnt[i], m_tc[i], m_ovf[i]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_prescale();
    test_saturate();
    test_priority();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
Parametrised up/down binary counter with programmable modulus, prescaler, synchronous load/clear, wrap or saturate mode, terminal-count pulse and sticky overflow flag. Successor to the fixed 4-bit up/down counter with enable. It sits behind the top-level pin wrapper: control bits come from dedicated inputs, and the count drives dedicated outputs.

Parameters:
WIDTH, 8, counter width in bits (>=2).
MAX_VAL, 2**WIDTH-1, top of count range; count spans 0..MAX_VAL (1 <= MAX_VAL <= 2**WIDTH-1).
PRESCALE, 1, enabled cycles per count step (>=1); 1 means a step every enabled cycle.
SATURATE, 0, 0 = wrap at range ends, 1 = hold at range ends.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous active-high reset.
test  in  1  1 = bypass prescaler, a step every enabled cycle.
en  in  1  count enable.
ud  in  1  direction: 1 = up, 0 = down.
clr  in  1  synchronous clear to 0.
load  in  1  synchronous load of load_val.
load_val  in  WIDTH  value to load.
ovf_clr  in  1  clears sticky ovf.
cnt  out  WIDTH  current count, registered.
tc  out  1  terminal-count pulse, registered, 1 cycle.
ovf  out  1  sticky boundary-event flag, registered.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst). All outputs are registered.
- Reset, while rst=1: cnt=0, tc=0, ovf=0, prescaler counter=0.
- Reset asserted mid-count clears everything immediately, with no clock edge needed. The first step after release needs a full prescale period.
- Per-edge priority: clr > load > count step. Each edge takes exactly one action.
- clr=1: cnt<=0, prescaler<=0, tc<=0. ovf is unaffected.
- load=1 (clr=0):
  - cnt <= load_val when load_val <= MAX_VAL; otherwise cnt <= MAX_VAL.
  - prescaler <= 0, tc <= 0.
- Prescaler, PRESCALE > 1 and test=0:
  - Internal counter of width $clog2(PRESCALE), advancing only when en=1.
  - tick = en && (pre == PRESCALE-1). On tick, pre <= 0; otherwise pre <= pre+1 while en=1.
  - en=0 holds pre.
- When PRESCALE==1 or test=1: tick = en. pre is held at 0 while test=1.
- A direction change does not reset the prescaler.
- Step on tick:
  - Up, cnt<MAX_VAL: cnt+1. Down, cnt>0: cnt-1.
  - Boundary event = tick with (ud=1 and cnt==MAX_VAL) or (ud=0 and cnt==0).
  - Boundary, SATURATE=0: up wraps MAX_VAL->0, down wraps 0->MAX_VAL.
  - Boundary, SATURATE=1: cnt holds.
- tc <= 1 on the edge that processes a boundary event, else 0. tc is high for exactly one cycle per event. In saturate mode, repeated ticks at a boundary give one tc pulse per tick.
- ovf:
  - Set on any boundary event.
  - Cleared by ovf_clr=1 when no boundary event occurs on that edge.
  - Simultaneous set and clear: set wins.
- If cnt holds a value above MAX_VAL, it is treated as MAX_VAL. This state cannot occur after reset.
- Arithmetic is WIDTH bits, unsigned. No intermediate overflow beyond WIDTH.

Test Plan:
1. WIDTH=4, MAX_VAL=9, PRESCALE=1, wrap; rst pulse, then en=1, ud=1 for 12 cycles -> cnt 1..9,0,1,2; tc=1 only the cycle after cnt=9; ovf=1 from then on.
2. Same config, ud=0 from cnt=0 for 3 cycles -> cnt 9,8,7; tc pulses once; ovf_clr=1 on a non-boundary cycle -> ovf=0 next cycle.
3. PRESCALE=3: en=1, ud=1, test=0 for 9 cycles -> cnt steps 0->1->2->3 on cycles 3,6,9. Repeat with test=1 -> a step every cycle. Toggle en=0 mid-prescale -> the step is delayed by the number of en=0 cycles.
4. SATURATE=1, MAX_VAL=9: load_val=9, load=1, then en=1, ud=1 for 3 cycles -> cnt stays 9 with tc=1 each cycle. load_val=15 -> cnt=9 (clamped). clr and load together -> cnt=0.
5. Priority and simultaneity: load=1 with en=1 at cnt=9 -> cnt=load_val and tc=0. ovf_clr=1 on a boundary-event edge -> ovf stays 1.
6. Asynchronous reset mid-count: with cnt=5, assert rst between clock edges -> cnt=0, tc=0, ovf=0 immediately. Release -> the first step comes after PRESCALE enabled cycles.
